// File: rtl/gcd_control_if.sv
// ---------------------------------------------------------------------------
// gcd_control_if
// Groups the host handshake and the datapath control/status signals of the
// subtract-based GCD unit.
//   master : the controller (drives mux selects, load enables, status, iter)
//   slave  : host + datapath side (drives go and the eqflg/ltflg status)
// Signals:
//   go           host request, level, four-phase handshake
//   eqflg/ltflg  datapath status x==y / x<y
//   xmsel/ymsel  x/y mux selects (1 = external operand, 0 = difference)
//   xld/yld/gld  x, y and gcd register load enables
//   busy/done/err controller status
//   iter         subtract iterations of current/last operation
// ---------------------------------------------------------------------------
interface gcd_control_if #(
    parameter int unsigned ITER_W = 4
);
    logic              go;
    logic              eqflg;
    logic              ltflg;
    logic              xmsel;
    logic              ymsel;
    logic              xld;
    logic              yld;
    logic              gld;
    logic              busy;
    logic              done;
    logic              err;
    logic [ITER_W-1:0] iter;

    modport master (
        input  go, eqflg, ltflg,
        output xmsel, ymsel, xld, yld, gld, busy, done, err, iter
    );

    modport slave (
        output go, eqflg, ltflg,
        input  xmsel, ymsel, xld, yld, gld, busy, done, err, iter
    );
endinterface

// File: rtl/gcd_control.sv
// ---------------------------------------------------------------------------
// gcd_control
// Control FSM for a 4-bit subtract-based GCD datapath. Loads the operands,
// subtracts the smaller from the larger until the datapath reports x==y,
// then loads the gcd register. An iteration limit turns non-converging
// operand pairs (one operand zero) into an error instead of a hang.
// Ports:
//   clk    system clock, rising edge
//   clr_n  asynchronous active-low reset
//   bus    gcd_control_if.master (handshake, datapath controls, status)
// Outputs are Mealy-decoded from the state (and the flags in TEST); iter is
// a register.
// ---------------------------------------------------------------------------
module gcd_control #(
    parameter int unsigned MAX_ITER = 15,
    parameter int unsigned ITER_W   = 4
) (
    input  logic          clk,
    input  logic          clr_n,
    gcd_control_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_TEST = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ITER_W-1:0] iter_q;
    logic [ITER_W-1:0] iter_nxt;
    logic              at_limit_c;

    logic xmsel_c;
    logic ymsel_c;
    logic xld_c;
    logic yld_c;
    logic gld_c;
    logic busy_c;
    logic done_c;
    logic err_c;

    assign at_limit_c = (iter_q == ITER_W'(MAX_ITER));

    // State and iteration counter registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= S_IDLE;
            iter_q <= '0;
        end else begin
            state  <= state_nxt;
            iter_q <= iter_nxt;
        end
    end

    // Next-state and next-iteration logic; eq has priority over the limit so
    // an operation that converges on the last allowed step still completes
    always_comb begin
        state_nxt = state;
        iter_nxt  = iter_q;
        unique case (state)
            S_IDLE: begin
                if (bus.go) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                iter_nxt  = '0;
                state_nxt = S_TEST;
            end
            S_TEST: begin
                if (bus.eqflg) begin
                    state_nxt = S_DONE;
                end else if (at_limit_c) begin
                    state_nxt = S_ERR;
                end else begin
                    iter_nxt = iter_q + ITER_W'(1);
                end
            end
            S_DONE, S_ERR: begin
                if (!bus.go) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode; in TEST exactly one of gld/yld/xld or none (limit hit)
    always_comb begin
        xmsel_c = 1'b0;
        ymsel_c = 1'b0;
        xld_c   = 1'b0;
        yld_c   = 1'b0;
        gld_c   = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        err_c   = 1'b0;
        unique case (state)
            S_LOAD: begin
                xmsel_c = 1'b1;
                ymsel_c = 1'b1;
                xld_c   = 1'b1;
                yld_c   = 1'b1;
                busy_c  = 1'b1;
            end
            S_TEST: begin
                busy_c = 1'b1;
                if (bus.eqflg) begin
                    gld_c = 1'b1;
                end else if (!at_limit_c) begin
                    if (bus.ltflg) begin
                        yld_c = 1'b1;
                    end else begin
                        xld_c = 1'b1;
                    end
                end
            end
            S_DONE: begin
                done_c = 1'b1;
            end
            S_ERR: begin
                err_c = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.xmsel = xmsel_c;
    assign bus.ymsel = ymsel_c;
    assign bus.xld   = xld_c;
    assign bus.yld   = yld_c;
    assign bus.gld   = gld_c;
    assign bus.busy  = busy_c;
    assign bus.done  = done_c;
    assign bus.err   = err_c;
    assign bus.iter  = iter_q;

`ifndef SYNTHESIS
    // Structural invariants of the controller
    a_one_load: assert property (@(posedge clk) disable iff (!clr_n)
        (state == S_TEST) |-> $onehot0({xld_c, yld_c, gld_c}));
    a_iter_bound: assert property (@(posedge clk) disable iff (!clr_n)
        iter_q <= ITER_W'(MAX_ITER));
`endif

endmodule

// File: tb/tb_gcd_control.sv
module tb_gcd_control;
    localparam int unsigned MAX_ITER = 15;
    localparam int unsigned ITER_W   = 4;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    gcd_control_if #(.ITER_W(ITER_W)) bus ();

    gcd_control #(.MAX_ITER(MAX_ITER), .ITER_W(ITER_W)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    // Datapath attached to the controller
    logic [3:0] xin = '0;
    logic [3:0] yin = '0;
    logic [3:0] x   = '0;
    logic [3:0] y   = '0;
    logic [3:0] g   = '0;
    logic use_rand = 1'b0;
    logic eq_rand  = 1'b0;
    logic lt_rand  = 1'b0;
    int   gld_seen = 0;

    assign bus.eqflg = use_rand ? eq_rand : (x == y);
    assign bus.ltflg = use_rand ? lt_rand : (x < y);

    always @(posedge clk) begin
        if (bus.xld) x <= bus.xmsel ? xin : 4'(x - y);
        if (bus.yld) y <= bus.ymsel ? yin : 4'(y - x);
        if (bus.gld) g <= x;
        if (bus.gld) gld_seen <= gld_seen + 1;
    end

    int total = 0;
    int bad   = 0;
    int last_g = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] outs();
        return {bus.xmsel, bus.ymsel, bus.xld, bus.yld, bus.gld, bus.busy, bus.done, bus.err};
    endfunction

    // Reference: Euclid by division; subtraction count = sum of quotients - 1
    function automatic void ref_gcd(input int a, input int b, output int gg, output int n,
                                    output bit e);
        int p, q, t, sum;
        e = 1'b0; n = 0; gg = 0;
        if (a == b) begin
            gg = a;
            return;
        end
        if (a == 0 || b == 0) begin
            e = 1'b1;
            n = int'(MAX_ITER);
            return;
        end
        p = a; q = b; sum = 0;
        while (q != 0) begin
            sum += p / q;
            t = p % q;
            p = q;
            q = t;
        end
        gg = p;
        n  = sum - 1;
        if (n > int'(MAX_ITER)) begin
            e = 1'b1;
            n = int'(MAX_ITER);
        end
    endfunction

    // Continuous invariant: never more than one register load in a cycle
    always @(negedge clk) begin
        if (clr_n && !use_rand && bus.busy && !bus.xmsel) begin
            check_val("one_load", 32'($countones({bus.xld, bus.yld, bus.gld})), 32'(bus.xld | bus.yld | bus.gld));
        end
    end

    // mode 0: hold go through result; 1: single-cycle go; 2: toggle go during TEST
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int mode);
        int eg, en, edges, g0;
        bit ee, hit;
        ref_gcd(int'(a), int'(b), eg, en, ee);
        if (ee) eg = last_g;
        @(negedge clk);
        xin = a; yin = b; bus.go = 1'b1;
        @(posedge clk);
        #1;
        g0 = gld_seen;
        check_val("load_outs", 32'(outs()), 32'(8'b1111_0100));
        if (mode == 1) bus.go = 1'b0;
        edges = 0; hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            edges++;
            #1;
            if (bus.done || bus.err) begin
                hit = 1'b1;
                break;
            end
            if (mode == 2) bus.go = ~bus.go;
        end
        check_val("finished", 32'(hit), 32'd1);
        check_val("done", 32'(bus.done), 32'(!ee));
        check_val("err", 32'(bus.err), 32'(ee));
        check_val("latency", 32'(edges), 32'(en + 2));
        check_val("iter", 32'(bus.iter), 32'(en));
        check_val("gcd", 32'(g), 32'(eg));
        check_val("gld_pulses", 32'(gld_seen - g0), ee ? 32'd0 : 32'd1);
        if (mode == 0) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                #1;
                check_val("hold_outs", 32'(outs()), ee ? 32'd1 : 32'd2);
            end
        end
        bus.go = 1'b0;
        @(posedge clk);
        #1;
        check_val("idle_outs", 32'(outs()), 32'd0);
        check_val("idle_iter", 32'(bus.iter), 32'(en));
        last_g = eg;
    endtask

    initial begin
        bus.go = 1'b1;
        use_rand = 1'b1;
        // Reset held with go high and arbitrary flags
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            eq_rand = 1'($urandom);
            lt_rand = 1'($urandom);
            #1;
            check_val("rst_outs", 32'(outs()), 32'd0);
            check_val("rst_iter", 32'(bus.iter), 32'd0);
        end
        @(negedge clk);
        bus.go = 1'b0;
        use_rand = 1'b0;
        clr_n = 1'b1;

        run_op(4'd12, 4'd8, 0);
        run_op(4'd5,  4'd5, 1);
        run_op(4'd15, 4'd1, 0);
        run_op(4'd0,  4'd7, 0);
        run_op(4'd9,  4'd6, 0);
        run_op(4'd3,  4'd9, 2);
        run_op(4'd14, 4'd4, 1);

        // Asynchronous reset while in TEST
        @(negedge clk);
        xin = 4'd0; yin = 4'd7; bus.go = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check_val("pre_rst_busy", 32'(bus.busy), 32'd1);
        clr_n = 1'b0;
        #1;
        check_val("async_outs", 32'(outs()), 32'd0);
        check_val("async_iter", 32'(bus.iter), 32'd0);
        @(negedge clk);
        bus.go = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        run_op(4'd6, 4'd15, 0);

        for (int k = 0; k < 40; k++) begin
            run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
